// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a reloadable pattern, overlap control
// and a saturating hit counter.
module seq_detect_param #(
   parameter int PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN = PATTERN_W'(4'b1101),
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in,
   input  logic                 in_valid,
   input  logic                 overlap,
   input  logic                 pat_load,
   input  logic [PATTERN_W-1:0] pat_in,
   output logic                 out,
   output logic                 out_q,
   output logic [CNT_W-1:0]     match_cnt
);

   localparam int FILL_W = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_W - 1);

   logic [PATTERN_W-1:0] pat;
   logic [PATTERN_W-1:0] ps;
   logic [PATTERN_W-1:0] ns;
   logic [FILL_W-1:0]    fill;
   logic [FILL_W-1:0]    fill_inc;

   always_comb begin
      ns       = {ps[PATTERN_W-2:0], in};
      fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
      // fill guard keeps cleared-history zeros from forming a match
      out = in_valid & ~pat_load & ~rst & (fill >= FILL_ARM) & (ns == pat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat       <= PATTERN;
         ps        <= '0;
         fill      <= '0;
         out_q     <= 1'b0;
         match_cnt <= '0;
      end else begin
         out_q <= out;
         if (pat_load) begin
            pat       <= pat_in;
            ps        <= '0;
            fill      <= '0;
            match_cnt <= '0;
         end else if (in_valid) begin
            if (out && !overlap) begin
               ps   <= '0;
               fill <= '0;
            end else begin
               ps   <= ns;
               fill <= fill_inc;
            end
            if (out && match_cnt != {CNT_W{1'b1}}) begin
               match_cnt <= match_cnt + 1'b1;
            end
         end
      end
   end

endmodule
